// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - multi-channel button debouncer with press/release pulses
module btn_debounce #(
    parameter int W = 2,
    parameter int N = 500000
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [W-1:0] BTN_RAW,
    output logic [W-1:0] BTN,
    output logic [W-1:0] BTN_PRESS,
    output logic [W-1:0] BTN_RELEASE
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [W-1:0] sync1;
    logic [W-1:0] s;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= BTN_RAW;
            s     <= sync1;
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_chan
        state_t        state, state_nx;
        logic [CW-1:0] cnt, cnt_nx;
        logic          btn_q, btn_nx;
        logic          press_q, press_nx;
        logic          release_q, release_nx;

        always_comb begin
            state_nx   = state;
            cnt_nx     = cnt;
            btn_nx     = btn_q;
            press_nx   = 1'b0;
            release_nx = 1'b0;
            case (state)
                RELEASED: begin
                    if (s[i]) begin
                        state_nx = PRESS_WAIT;
                        cnt_nx   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s[i]) begin
                        state_nx = RELEASED;
                    end else if (cnt == LAST) begin
                        state_nx = PRESSED;
                        btn_nx   = 1'b1;
                        press_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s[i]) begin
                        state_nx = RELEASE_WAIT;
                        cnt_nx   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (s[i]) begin
                        state_nx = PRESSED;
                    end else if (cnt == LAST) begin
                        state_nx   = RELEASED;
                        btn_nx     = 1'b0;
                        release_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = RELEASED;
                    cnt_nx   = '0;
                    btn_nx   = 1'b0;
                end
            endcase
        end

        always_ff @(posedge CLK) begin
            if (RESET) begin
                state     <= RELEASED;
                cnt       <= '0;
                btn_q     <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_nx;
                cnt       <= cnt_nx;
                btn_q     <= btn_nx;
                press_q   <= press_nx;
                release_q <= release_nx;
            end
        end

        assign BTN[i]         = btn_q;
        assign BTN_PRESS[i]   = press_q;
        assign BTN_RELEASE[i] = release_q;
    end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter W, default 2: number of independent button channels; W SHALL be at least 1.
REQ-002 Parameter N, default 500000: debounce stability window in clock cycles; N SHALL be at least 1.
REQ-003 Port CLK, input, 1 bit: single clock; all state SHALL update on the rising edge.
REQ-004 Port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port BTN_RAW, input, W bits: asynchronous, bouncy button levels; 1 = pressed.
REQ-006 Port BTN, output, W bits: debounced level, registered; feeds the gate/LED logic stage directly.
REQ-007 Port BTN_PRESS, output, W bits: one-cycle pulse on each debounced 0->1 transition.
REQ-008 Port BTN_RELEASE, output, W bits: one-cycle pulse on each debounced 1->0 transition.

Function
REQ-009 Each channel SHALL pass BTN_RAW[i] through a 2-flop synchronizer; the second flop output is s[i], and no other logic SHALL read BTN_RAW.
REQ-010 Each channel SHALL contain an independent FSM and counter, with counter width ceil(log2(N)), minimum 1.
REQ-011 FSM states per channel SHALL be: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 RELEASED: when s=1, go to PRESS_WAIT and clear the counter; otherwise hold.
REQ-013 PRESS_WAIT, case s=0: return to RELEASED with no output change (bounce rejected).
REQ-014 PRESS_WAIT, case s=1 and cnt<N-1: increment cnt.
REQ-015 PRESS_WAIT, case s=1 and cnt=N-1: go to PRESSED; BTN[i]<=1 and BTN_PRESS[i]<=1 on the same edge.
REQ-016 PRESSED: when s=0, go to RELEASE_WAIT and clear the counter; otherwise hold.
REQ-017 RELEASE_WAIT, case s=1: return to PRESSED with no output change.
REQ-018 RELEASE_WAIT, case s=0 and cnt<N-1: increment cnt.
REQ-019 RELEASE_WAIT, case s=0 and cnt=N-1: go to RELEASED; BTN[i]<=0 and BTN_RELEASE[i]<=1 on the same edge.
REQ-020 Latency: if BTN_RAW[i] is first sampled high at edge k and stays high, BTN[i] and BTN_PRESS[i] SHALL rise at edge k+N+2; release is symmetric.
REQ-021 BTN_PRESS and BTN_RELEASE SHALL each be high for exactly one cycle per transition and SHALL never be high together on one channel.
REQ-022 A glitch shorter than the remaining window SHALL restart qualification from RELEASED (or PRESSED); counts SHALL never accumulate across a bounce.
REQ-023 The counter SHALL never exceed N-1 and SHALL never wrap.
REQ-024 BTN[i] SHALL be 1 exactly in states PRESSED and RELEASE_WAIT.
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL each behave as if alone.

Reset
REQ-026 While RESET=1 at an edge, the following SHALL be cleared: synchronizer flops to 0, all FSMs to RELEASED, counters to 0, and BTN, BTN_PRESS, BTN_RELEASE to 0.
REQ-027 Reset mid-operation (any state, any count) SHALL abort that operation; no press or release pulse SHALL be emitted because of reset.
REQ-028 A button held through reset SHALL be detected as a fresh press: BTN rises at edge r+N+2, where r is the first edge with RESET=0.

Verification (N=4, W=2)
REQ-029 Clean press: BTN_RAW[0]=1 sampled first at edge 10 and held -> BTN[0]=1 and BTN_PRESS[0]=1 at edge 16; BTN_PRESS[0]=0 at edge 17; BTN[1] stays 0.
REQ-030 Bounce: BTN_RAW[0] high at edges 10-11, low at 12, high from 13 -> no pulse before edge 19; BTN[0] rises at edge 19.
REQ-031 Release: BTN_RAW[0] falls at sampled edge 30 after a settled press -> BTN[0]=0 and BTN_RELEASE[0]=1 at edge 36; a 1-cycle high glitch at edge 32 delays this to edge 39.
REQ-032 Reset mid-wait: RESET=1 at edge 13 during PRESS_WAIT with BTN_RAW held -> all outputs 0 at edge 13; BTN rises at edge 20 (first edge with RESET=0 is 14); no pulse at edge 13.
REQ-033 Simultaneous: BTN_RAW=2'b11 from edge 10 -> BTN=2'b11 and BTN_PRESS=2'b11 at edge 16; releasing only channel 1 from edge 20 -> BTN=2'b01 at edge 26.
